rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter for a single shared resource.
- Registered grant is presented both as a 2-bit index and as the matching one-hot 4-bit select (00→0001, 01→0010, 10→0100, 11→1000), so it drives resource enables directly.
- Sits between request sources and the shared resource.
- Owner holds the grant until it drops its request, or until a hold limit expires when the optional feature is compiled in.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner before forced release (only with ARB_TIMEOUT_EN). Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  4  request vector; bit i set = requester i wants the resource.
- gnt  output  4  one-hot grant; 0000 when no owner.
- gnt_idx  output  2  index of current owner; holds last owner value while gnt_valid=0.
- gnt_valid  output  1  high while a grant is active.
- preempt  output  1  one-cycle pulse when an owner is forcibly released; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Clocking and reset:
  - All outputs registered.
  - Reset is synchronous, active-high, sampled on the clk rising edge.
  - Reset values: gnt=0000, gnt_idx=00, gnt_valid=0, preempt=0, priority pointer ptr=00, hold counter=0, state=IDLE.
  - Reset asserted mid-grant drops the grant on the next edge; no release bookkeeping is performed.
- Encoding:
  - gnt equals the one-hot decode of gnt_idx when gnt_valid=1, else 0000.
  - gnt never has more than one bit set.
- Arbitration function:
  - Select the first set bit of the candidate vector, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- State IDLE:
  - If req≠0000: arbitrate over req. Next edge: gnt_valid=1, gnt_idx=winner, counter=0, state=GRANT.
  - Latency is one cycle from req sampled to gnt visible.
  - If req=0000: stay in IDLE, outputs unchanged.
- State GRANT, owner keeps request (req[gnt_idx]=1):
  - Grant holds and counter increments (saturating).
- State GRANT, owner releases (req[gnt_idx]=0), handled in the same sampled cycle:
  - ptr ← gnt_idx+1 (mod 4).
  - Arbitrate over req with the owner bit masked, using the new ptr.
  - If a winner exists: next edge grants it directly. No idle bubble; gnt switches one-hot to one-hot; counter=0.
  - Otherwise: gnt_valid=0, gnt=0000, state=IDLE.
- Simultaneous requests: resolved purely by ptr rotation. After reset, requester 0 has highest priority.
- Requests arriving during a grant: no effect until release.
- Requester drops req while not owner: no effect.
- ptr changes only on release or preempt, never in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - When in GRANT, the counter equals MAX_HOLD-1 and req[gnt_idx]=1: forced release.
  - Forced release: ptr ← gnt_idx+1 and preempt=1 for one cycle (coincident with the new grant edge).
  - Re-arbitrate with the owner masked. If another requester wins, it is granted next edge.
  - If no other request exists, the same owner is re-granted: gnt stays asserted, counter=0, preempt still pulses.
  - Owner therefore holds at most MAX_HOLD consecutive cycles while others wait.
- Without the macro:
  - No hold limit; counter logic removed.
  - preempt tied to 0.
  - MAX_HOLD ignored.

Test Plan:
- Reset with req=1111 held → gnt=0000, gnt_valid=0 during reset. First edge after reset release → gnt=0001, gnt_idx=00.
- Round-robin: all four requesters hold req=1111, each releases after 2 cycles then re-requests → grant order 0,1,2,3,0 with no idle cycle between owners.
- Release with no waiters: req=0100 for 3 cycles then 0000 → gnt=0100 for 3 cycles, then 0000 one cycle after the drop, gnt_valid=0, next req=0001 granted after one cycle.
- Pointer rotation: owner 2 releases while req=1011 → next gnt=1000 (idx 3), not 0001.
- Mid-grant reset: gnt=0010, assert rst one cycle → gnt=0000, ptr=0. With req=0011 after reset → gnt=0001.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=0011 held → gnt=0001 for 4 cycles, then 0010 with preempt=1 for one cycle. With req=0001 only → gnt stays 0001, preempt pulses every 4 cycles. Without the macro → preempt never asserts.

Source files
------------

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side drives requests; the slave side is the arbiter.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered index and one-hot grant.
// Define ARB_TIMEOUT_EN to add the MAX_HOLD hold limit and the preempt pulse.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_4_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [1:0] ptr;
    logic [1:0] ptr_n;
    logic [1:0] idx;
    logic [1:0] idx_n;
    logic       valid;
    logic       valid_n;
    logic [3:0] gnt_q;
    logic [3:0] gnt_n;
    logic       preempt_q;
    logic       preempt_n;
    logic       owner_req;
    logic       hold_expired;
    logic [3:0] cand;
    logic [2:0] pick;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_hold_range
        $error("rr_arbiter_4: MAX_HOLD must be within 2..255");
    end

    // Returns {found, index}; the lowest rotation offset from start wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
        logic [1:0] k;
        rr_pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            k = start + 2'(i);
            if (vec[k]) rr_pick = {1'b1, k};
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        onehot = 4'b0001 << i;
    endfunction

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic [7:0] cnt_n;

    assign hold_expired = (state == GRANT) && bus.req[idx] && (cnt == 8'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        idx_n     = idx;
        valid_n   = valid;
        preempt_n = 1'b0;
        cand      = 4'b0000;
        pick      = 3'b000;
        owner_req = bus.req[idx];
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    pick    = rr_pick(bus.req, ptr);
                    idx_n   = pick[1:0];
                    valid_n = 1'b1;
                    state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_n   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req || hold_expired) begin
                    // Release and re-arbitrate in the same cycle so owners switch without a bubble.
                    ptr_n     = idx + 2'd1;
                    cand      = bus.req & ~onehot(idx);
                    pick      = rr_pick(cand, ptr_n);
                    preempt_n = hold_expired;
`ifdef ARB_TIMEOUT_EN
                    cnt_n     = 8'd0;
`endif
                    if (pick[2]) begin
                        idx_n = pick[1:0];
                    end else if (!hold_expired) begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = valid_n ? onehot(idx_n) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            idx       <= 2'd0;
            valid     <= 1'b0;
            gnt_q     <= 4'b0000;
            preempt_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt       <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            idx       <= idx_n;
            valid     <= valid_n;
            gnt_q     <= gnt_n;
            preempt_q <= preempt_n;
`ifdef ARB_TIMEOUT_EN
            cnt       <= cnt_n;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx;
    assign bus.gnt_valid = valid;
`ifdef ARB_TIMEOUT_EN
    assign bus.preempt   = preempt_q;
`else
    assign bus.preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; hold-limit checks use MAX_HOLD=4 under ARB_TIMEOUT_EN.
module tb_rr_arbiter_4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        tick();
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got gnt=%b valid=%b idx=%0d pre=%b exp gnt=0000 valid=0 idx=0 pre=0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.preempt);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL first_grant got gnt=%b valid=%b idx=%0d exp gnt=0001 valid=1 idx=0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] hold_exp;
        logic [3:0] next_exp;
        for (int k = 0; k < 4; k++) begin
            hold_exp = 4'b0001 << k;
            next_exp = 4'b0001 << ((k + 1) % 4);
            bus.req = 4'b1111;
            tick();
            vectors++;
            if (bus.gnt !== hold_exp || bus.gnt_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_hold k=%0d got gnt=%b valid=%b exp gnt=%b valid=1", k, bus.gnt, bus.gnt_valid, hold_exp);
            end
            bus.req = 4'b1111 & ~hold_exp;
            tick();
            vectors++;
            if (bus.gnt !== next_exp || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'((k + 1) % 4)) begin
                miscompares++;
                $display("FAIL rr_switch k=%0d got gnt=%b valid=%b idx=%0d exp gnt=%b valid=1 idx=%0d",
                         k, bus.gnt, bus.gnt_valid, bus.gnt_idx, next_exp, (k + 1) % 4);
            end
        end
        bus.req = 4'b0000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL rr_idle got gnt=%b valid=%b idx=%0d exp gnt=0000 valid=0 idx=0", bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
    endtask

    task automatic test_release_no_waiters();
        bus.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.gnt !== 4'b0100 || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd2) begin
                miscompares++;
                $display("FAIL solo_hold cyc=%0d got gnt=%b valid=%b idx=%0d exp gnt=0100 valid=1 idx=2",
                         i, bus.gnt, bus.gnt_valid, bus.gnt_idx);
            end
        end
        bus.req = 4'b0000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL solo_release got gnt=%b valid=%b idx=%0d exp gnt=0000 valid=0 idx=2", bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
        bus.req = 4'b0001;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1 || bus.gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL solo_regrant got gnt=%b valid=%b idx=%0d exp gnt=0001 valid=1 idx=0", bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
    endtask

    task automatic test_ptr_rotation();
        bus.req = 4'b0100;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL ptr_setup got gnt=%b exp gnt=0100", bus.gnt);
        end
        bus.req = 4'b1011;
        tick();
        vectors++;
        if (bus.gnt !== 4'b1000 || bus.gnt_idx !== 2'd3) begin
            miscompares++;
            $display("FAIL ptr_rotate got gnt=%b idx=%0d exp gnt=1000 idx=3", bus.gnt, bus.gnt_idx);
        end
        bus.req = 4'b1111;
        tick();
        vectors++;
        if (bus.gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL late_requests got gnt=%b exp gnt=1000", bus.gnt);
        end
    endtask

    task automatic test_mid_reset();
        bus.req = 4'b0010;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL midrst_setup got gnt=%b exp gnt=0010", bus.gnt);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_drop got gnt=%b valid=%b idx=%0d exp gnt=0000 valid=0 idx=0", bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
        rst = 1'b0;
        bus.req = 4'b0011;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.gnt_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL midrst_ptr got gnt=%b idx=%0d exp gnt=0001 idx=0", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_nonowner_drop();
        bus.req = 4'b0001;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL nonowner_drop got gnt=%b valid=%b exp gnt=0001 valid=1", bus.gnt, bus.gnt_valid);
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp_gnt;
        logic       exp_pre;
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
        bus.req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_gnt = (i < 4) ? 4'b0001 : 4'b0010;
            exp_pre = (i == 4);
            vectors++;
            if (bus.gnt !== exp_gnt || bus.preempt !== exp_pre) begin
                miscompares++;
                $display("FAIL timeout_pair cyc=%0d got gnt=%b pre=%b exp gnt=%b pre=%b", i, bus.gnt, bus.preempt, exp_gnt, exp_pre);
            end
        end
        bus.req = 4'b0001;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0001 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_handback got gnt=%b pre=%b exp gnt=0001 pre=0", bus.gnt, bus.preempt);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            exp_pre = (j % 4 == 0);
            vectors++;
            if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1 || bus.preempt !== exp_pre) begin
                miscompares++;
                $display("FAIL timeout_solo j=%0d got gnt=%b valid=%b pre=%b exp gnt=0001 valid=1 pre=%b",
                         j, bus.gnt, bus.gnt_valid, bus.preempt, exp_pre);
            end
        end
`else
        exp_gnt = 4'b0001;
        exp_pre = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (bus.gnt !== exp_gnt || bus.preempt !== exp_pre) begin
                miscompares++;
                $display("FAIL no_timeout cyc=%0d got gnt=%b pre=%b exp gnt=%b pre=%b", i, bus.gnt, bus.preempt, exp_gnt, exp_pre);
            end
        end
`endif
        bus.req = 4'b0000;
        tick();
        vectors++;
        if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.preempt !== 1'b0) begin
            miscompares++;
            $display("FAIL final_idle got gnt=%b valid=%b pre=%b exp gnt=0000 valid=0 pre=0", bus.gnt, bus.gnt_valid, bus.preempt);
        end
    endtask

    initial begin
        bus.req = 4'b0000;
        test_reset();
        test_round_robin();
        test_release_no_waiters();
        test_ptr_rotation();
        test_mid_reset();
        test_nonowner_drop();
        test_hold_limit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
